id_ex_operand_stage: RTL

//  ID/EX pipeline register plus EX operand selection. Sits directly upstream of the ALU.

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/forward_unit.sv | 24 ++
 rtl/id_ex_operand_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the ID/EX operand stage
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam int RAW  = 5;

  localparam logic [OPW-1:0] ALU_AND = 4'd0;
  localparam logic [OPW-1:0] ALU_OR  = 4'd1;
  localparam logic [OPW-1:0] ALU_ADD = 4'd2;
  localparam logic [OPW-1:0] ALU_SUB = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR = 4'd4;
  localparam logic [OPW-1:0] ALU_EQ  = 4'd8;

  // FWD_MEM takes the EX/MEM result, FWD_WB the MEM/WB writeback value
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [OPW-1:0]  alu_op;
    logic            mem_read;
    logic            reg_write;
  } id_ex_t;

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t sel,
                                              input logic [XLEN-1:0] reg_data,
                                              input logic [XLEN-1:0] exm_data,
                                              input logic [XLEN-1:0] mwb_data);
    case (sel)
      FWD_MEM: return exm_data;
      FWD_WB:  return mwb_data;
      default: return reg_data;
    endcase
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - per-source forwarding select, EX/MEM over MEM/WB, x0 never forwarded
module forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_reg_write,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_REG;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      sel = FWD_MEM;
    end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register, load-use bubble insertion and ALU operand forwarding
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OPW,
  parameter int REG_ADDR_W    = RAW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_mem_read,
  input  logic                     id_reg_write,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic                     exm_reg_write,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [REG_ADDR_W-1:0]    mwb_rd,
  input  logic                     mwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    mwb_result,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read
);

  id_ex_t   ex_q;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // A flush kills the dependent instruction anyway, so it must not also stall
  assign stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush || stall) begin
      ex_q <= '0;
    end else begin
      ex_q.valid     <= id_valid;
      ex_q.rs1       <= id_rs1;
      ex_q.rs2       <= id_rs2;
      ex_q.rd        <= id_rd;
      ex_q.rs1_data  <= id_rs1_data;
      ex_q.rs2_data  <= id_rs2_data;
      ex_q.imm       <= id_imm;
      ex_q.alu_src   <= id_alu_src;
      ex_q.alu_op    <= id_alu_op;
      ex_q.mem_read  <= id_valid && id_mem_read;
      ex_q.reg_write <= id_valid && id_reg_write;
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs            (ex_q.rs1),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .sel           (sel_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs            (ex_q.rs2),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .sel           (sel_b)
  );

  assign SrcA          = fwd_mux(sel_a, ex_q.rs1_data, exm_result, mwb_result);
  assign fwd_rs2       = fwd_mux(sel_b, ex_q.rs2_data, exm_result, mwb_result);
  assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;

endmodule
